pec_psum_checker: RTL and testbench
===================================

# pec_psum_checker

On-chip self-check block for the PE array's partial-sum write path. It is the parametrised, synthesizable successor of the per-PEC PECRAM_DatWr monitor. Expected psums are streamed into per-channel FIFOs, and every observed PECRAM write on each of NUM_CH channels is compared in parallel against them. The block accumulates error counts, captures the first mismatch, and raises done after a programmed number of checks. It sits beside the PEL and taps the PEC→PECRAM write strobes and data; it is read out through the debug register interface.

## Interface
- NUM_CH, 27, checked channels (NUMPEB×NUMPEC-per-PEB).
- PSUM_WIDTH, 22, psum data width.
- REF_DEPTH, 8, expected-value FIFO depth per channel (power of 2, ≥2).
- CNT_WIDTH, 16, width of check/error counters and CHK_Len.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset: synchronous, active-high; clears all state.
- REF_Val  in  1  expected-value push request.
- REF_Rdy  out  1  addressed FIFO (REF_Ch) not full; push occurs when REF_Val&REF_Rdy.
- REF_Ch  in  $clog2(NUM_CH)  target channel of push.
- REF_Dat  in  PSUM_WIDTH  expected psum.
- MON_EnWr  in  NUM_CH  per-channel observed write strobe.
- MON_DatWr  in  NUM_CH*PSUM_WIDTH  observed data, channel c at [c*PSUM_WIDTH +: PSUM_WIDTH].
- CHK_Start  in  1  pulse: clear counters/capture, enter RUN.
- CHK_Len  in  CNT_WIDTH  total checks to perform, sampled at CHK_Start.
- CHK_Tol  in  PSUM_WIDTH  absolute tolerance (used only with CHK_TOLERANCE_EN).
- CHK_Busy  out  1  state==RUN.
- CHK_Done  out  1  state==DONE.
- CHK_Cnt  out  CNT_WIDTH  checks performed.
- ERR_Cnt  out  CNT_WIDTH  mismatches, saturating.
- ERR_Uflow  out  1  sticky: strobe seen with empty FIFO.
- ERR_FirstVal  out  1  first-mismatch capture valid.
- ERR_FirstCh  out  $clog2(NUM_CH)  channel of first mismatch.
- ERR_FirstIdx  out  CNT_WIDTH  CHK_Cnt value at the first mismatch.
- ERR_FirstExp / ERR_FirstObs  out  PSUM_WIDTH each  expected/observed value at the first mismatch.

## Operation
- States: IDLE → (CHK_Start) RUN → (CHK_Cnt reaches latched length) DONE → (CHK_Start) RUN. CHK_Start in RUN restarts RUN. Length 0: RUN→DONE on the next cycle.
- Pushes are accepted in any state. Strobes are compared only in RUN; outside RUN, strobes are ignored and FIFOs are not popped.
- In RUN, each channel c with MON_EnWr[c]:
  - FIFO non-empty: pop the head, compare it with the observed data, count one check.
  - FIFO empty: set ERR_Uflow, count one check and one error; no pop.
- Match: exact equality (see Configuration).
- Multiple channels in one cycle: CHK_Cnt += popcount(checks), ERR_Cnt += popcount(errors).
- ERR_Cnt saturates at all-ones. CHK_Cnt does not saturate; it stops at the latched length.
- First capture: the lowest-index failing channel of the earliest failing cycle. Written once per RUN; later errors are ignored.
- Checks beyond the length in the final cycle: CHK_Cnt clamps to the length and excess strobes are dropped unpopped. The final cycle's errors all count.
- Push and pop on the same channel in one cycle:
  - REF_Rdy is based on the pre-pop count, so a full FIFO refuses the push.
  - On an empty FIFO, the pop is an underflow; the simultaneous push is stored with no bypass.
- FIFO pointers wrap modulo REF_DEPTH. FIFOs are not cleared by CHK_Start, only by rst.

## Timing
- Compare stage is registered: a strobe in cycle N updates the counters, capture and ERR_Uflow visible in cycle N+1.
- CHK_Done asserts in the cycle after the counter reaches the length.
- REF_Rdy is combinational from REF_Ch and FIFO occupancy. A push in cycle N is poppable from cycle N+1.
- Reset values: REF_Rdy=1, CHK_Busy=0, CHK_Done=0, all counters 0, ERR_Uflow=0, ERR_FirstVal=0, all capture fields 0, state IDLE, FIFOs empty.
- rst mid-RUN: everything returns to reset values on the next edge; in-flight compares are discarded.

## Configuration
- CHK_TOLERANCE_EN defined: a value matches when |obs−exp| ≤ CHK_Tol, using a signed PSUM_WIDTH+1-bit difference.
- CHK_TOLERANCE_EN undefined: exact equality only; CHK_Tol is unused.

## Test plan
- Exact stream: push 4 values per channel on ch0..2, Start with Len=12, matching strobes → Done after 12 checks, ERR_Cnt=0, ERR_FirstVal=0.
- Simultaneous errors: ch5 and ch3 mismatch in the same cycle as the first errors → ERR_Cnt+=2, ERR_FirstCh=3, Exp/Obs captured, FirstIdx equals the prior CHK_Cnt.
- Underflow: strobe on ch7 with an empty FIFO → ERR_Uflow=1, ERR_Cnt=1, no pointer change; a subsequent push and strobe match cleanly.
- Full FIFO with pop and push in the same cycle on ch0 (REF_DEPTH=8, 8 entries) → REF_Rdy=0, push refused, occupancy 7 afterwards.
- Tolerance (CHK_TOLERANCE_EN): exp=100, obs=102 → CHK_Tol=2 passes; CHK_Tol=1 counts an error. Repeat with exp=−5, obs=−8.
- rst mid-RUN with ERR_Cnt=3 → the next cycle shows all outputs at reset values, REF_Rdy=1 and FIFOs empty.

Source files
------------

// File: rtl/pec_psum_checker.sv
// Self-check for the PEC->PECRAM partial-sum write path: per-channel expected-value FIFOs
// compared against observed write strobes. Optional macro CHK_TOLERANCE_EN enables |obs-exp| <= CHK_Tol matching.
module pec_psum_checker #(
    parameter int NUM_CH     = 27,
    parameter int PSUM_WIDTH = 22,
    parameter int REF_DEPTH  = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W     = $clog2(REF_DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         REF_Val_i,
    output logic                         REF_Rdy_o,
    input  logic [CH_W-1:0]              REF_Ch_i,
    input  logic [PSUM_WIDTH-1:0]        REF_Dat_i,
    input  logic [NUM_CH-1:0]            MON_EnWr_i,
    input  logic [NUM_CH*PSUM_WIDTH-1:0] MON_DatWr_i,
    input  logic                         CHK_Start_i,
    input  logic [CNT_WIDTH-1:0]         CHK_Len_i,
    input  logic [PSUM_WIDTH-1:0]        CHK_Tol_i,
    output logic                         CHK_Busy_o,
    output logic                         CHK_Done_o,
    output logic [CNT_WIDTH-1:0]         CHK_Cnt_o,
    output logic [CNT_WIDTH-1:0]         ERR_Cnt_o,
    output logic                         ERR_Uflow_o,
    output logic                         ERR_FirstVal_o,
    output logic [CH_W-1:0]              ERR_FirstCh_o,
    output logic [CNT_WIDTH-1:0]         ERR_FirstIdx_o,
    output logic [PSUM_WIDTH-1:0]        ERR_FirstExp_o,
    output logic [PSUM_WIDTH-1:0]        ERR_FirstObs_o
);

    // state | meaning
    // IDLE  | after reset, nothing compared
    // RUN   | strobes compared against FIFO heads
    // DONE  | programmed number of checks reached
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [PSUM_WIDTH-1:0] mem_q    [NUM_CH][REF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_CH];
    logic [PTR_W:0]        occ_q    [NUM_CH];
    logic [PTR_W:0]        occ_d    [NUM_CH];

    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  chk_cnt_q, chk_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  uflow_q, uflow_d;
    logic                  first_val_q, first_val_d;
    logic [CH_W-1:0]       first_ch_q, first_ch_d;
    logic [CNT_WIDTH-1:0]  first_idx_q, first_idx_d;
    logic [PSUM_WIDTH-1:0] first_exp_q, first_exp_d;
    logic [PSUM_WIDTH-1:0] first_obs_q, first_obs_d;

    logic [NUM_CH-1:0]     push_vec;
    logic [NUM_CH-1:0]     pop_vec;
    logic                  ref_full;
    logic                  run_cmp;

    logic [CNT_WIDTH-1:0]  remaining;
    logic [CNT_WIDTH-1:0]  n_acc;
    logic [CNT_WIDTH-1:0]  n_err;
    logic [CNT_WIDTH:0]    err_sum;
    logic                  any_uflow;
    logic                  fail_any;
    logic [CH_W-1:0]       fail_ch;
    logic [PSUM_WIDTH-1:0] fail_exp;
    logic [PSUM_WIDTH-1:0] fail_obs;

`ifdef CHK_TOLERANCE_EN
    function automatic logic is_match(input logic [PSUM_WIDTH-1:0] exp_v,
                                      input logic [PSUM_WIDTH-1:0] obs_v,
                                      input logic [PSUM_WIDTH-1:0] tol_v);
        logic signed [PSUM_WIDTH:0] diff;
        logic [PSUM_WIDTH:0]        mag;
        diff = $signed({obs_v[PSUM_WIDTH-1], obs_v}) - $signed({exp_v[PSUM_WIDTH-1], exp_v});
        mag  = diff[PSUM_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        return mag <= {1'b0, tol_v};
    endfunction
`else
    function automatic logic is_match(input logic [PSUM_WIDTH-1:0] exp_v,
                                      input logic [PSUM_WIDTH-1:0] obs_v,
                                      input logic [PSUM_WIDTH-1:0] tol_v);
        logic unused_tol;
        unused_tol = ^tol_v;
        return (exp_v == obs_v) | (unused_tol & 1'b0);
    endfunction
`endif

    always_comb begin
        ref_full = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (REF_Ch_i == CH_W'(c) && occ_q[c] == (PTR_W+1)'(REF_DEPTH))
                ref_full = 1'b1;
        end
    end

    assign REF_Rdy_o = !ref_full;

    always_comb begin
        push_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            push_vec[c] = REF_Val_i && !ref_full && (REF_Ch_i == CH_W'(c));
        end
    end

    assign run_cmp   = (state_q == S_RUN) && !CHK_Start_i;
    assign remaining = len_q - chk_cnt_q;

    // Channels are scanned low to high so that truncation in the final cycle keeps the
    // lowest-index strobes, and the first capture picks the lowest failing channel.
    always_comb begin
        logic                  empty_c;
        logic [PSUM_WIDTH-1:0] head_c;
        logic [PSUM_WIDTH-1:0] obs_c;
        logic                  err_c;
        pop_vec   = '0;
        n_acc     = '0;
        n_err     = '0;
        any_uflow = 1'b0;
        fail_any  = 1'b0;
        fail_ch   = '0;
        fail_exp  = '0;
        fail_obs  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty_c = (occ_q[c] == '0);
            head_c  = empty_c ? '0 : mem_q[c][rd_ptr_q[c]];
            obs_c   = MON_DatWr_i[c*PSUM_WIDTH +: PSUM_WIDTH];
            err_c   = 1'b0;
            if (run_cmp && MON_EnWr_i[c]) begin
                err_c = empty_c || !is_match(head_c, obs_c, CHK_Tol_i);
                if (n_acc != remaining) begin
                    n_acc      = n_acc + 1'b1;
                    pop_vec[c] = !empty_c;
                end
                if (empty_c)
                    any_uflow = 1'b1;
                if (err_c) begin
                    n_err = n_err + 1'b1;
                    if (!fail_any) begin
                        fail_any = 1'b1;
                        fail_ch  = CH_W'(c);
                        fail_exp = head_c;
                        fail_obs = obs_c;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            occ_d[c]    = occ_q[c];
            if (push_vec[c])
                wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
            if (pop_vec[c])
                rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
            case ({push_vec[c], pop_vec[c]})
                2'b10:   occ_d[c] = occ_q[c] + 1'b1;
                2'b01:   occ_d[c] = occ_q[c] - 1'b1;
                default: occ_d[c] = occ_q[c];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (CHK_Start_i) state_d = S_RUN;
            S_RUN: begin
                if (CHK_Start_i)
                    state_d = S_RUN;
                else if (chk_cnt_q == len_q)
                    state_d = S_DONE;
            end
            S_DONE:  if (CHK_Start_i) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    assign err_sum = {1'b0, err_cnt_q} + {1'b0, n_err};

    always_comb begin
        len_d       = len_q;
        chk_cnt_d   = chk_cnt_q;
        err_cnt_d   = err_cnt_q;
        uflow_d     = uflow_q;
        first_val_d = first_val_q;
        first_ch_d  = first_ch_q;
        first_idx_d = first_idx_q;
        first_exp_d = first_exp_q;
        first_obs_d = first_obs_q;
        if (CHK_Start_i) begin
            len_d       = CHK_Len_i;
            chk_cnt_d   = '0;
            err_cnt_d   = '0;
            first_val_d = 1'b0;
            first_ch_d  = '0;
            first_idx_d = '0;
            first_exp_d = '0;
            first_obs_d = '0;
        end else if (run_cmp) begin
            chk_cnt_d = chk_cnt_q + n_acc;
            err_cnt_d = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
            uflow_d   = uflow_q | any_uflow;
            if (fail_any && !first_val_q) begin
                first_val_d = 1'b1;
                first_ch_d  = fail_ch;
                first_idx_d = chk_cnt_q;
                first_exp_d = fail_exp;
                first_obs_d = fail_obs;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
            uflow_q     <= 1'b0;
            first_val_q <= 1'b0;
            first_ch_q  <= '0;
            first_idx_q <= '0;
            first_exp_q <= '0;
            first_obs_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                occ_q[c]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            chk_cnt_q   <= chk_cnt_d;
            err_cnt_q   <= err_cnt_d;
            uflow_q     <= uflow_d;
            first_val_q <= first_val_d;
            first_ch_q  <= first_ch_d;
            first_idx_q <= first_idx_d;
            first_exp_q <= first_exp_d;
            first_obs_q <= first_obs_d;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                occ_q[c]    <= occ_d[c];
            end
        end
    end

    // Storage is not reset; emptiness is tracked by occ_q alone.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_vec[c])
                mem_q[c][wr_ptr_q[c]] <= REF_Dat_i;
        end
    end

    assign CHK_Busy_o     = (state_q == S_RUN);
    assign CHK_Done_o     = (state_q == S_DONE);
    assign CHK_Cnt_o      = chk_cnt_q;
    assign ERR_Cnt_o      = err_cnt_q;
    assign ERR_Uflow_o    = uflow_q;
    assign ERR_FirstVal_o = first_val_q;
    assign ERR_FirstCh_o  = first_ch_q;
    assign ERR_FirstIdx_o = first_idx_q;
    assign ERR_FirstExp_o = first_exp_q;
    assign ERR_FirstObs_o = first_obs_q;

endmodule

// File: tb/tb_pec_psum_checker.sv
// Directed bench for pec_psum_checker: exact stream, simultaneous errors, full FIFO, underflow,
// final-cycle truncation, zero length, reset mid-run, and tolerance when CHK_TOLERANCE_EN is defined.
module tb_pec_psum_checker;

    localparam int NC  = 27;
    localparam int PW  = 22;
    localparam int CW  = 16;
    localparam int CHW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             ref_val;
    logic             ref_rdy;
    logic [CHW-1:0]   ref_ch;
    logic [PW-1:0]    ref_dat;
    logic [NC-1:0]    mon_en;
    logic [NC*PW-1:0] mon_dat;
    logic             chk_start;
    logic [CW-1:0]    chk_len;
    logic [PW-1:0]    chk_tol;
    logic             busy;
    logic             done;
    logic [CW-1:0]    chk_cnt;
    logic [CW-1:0]    err_cnt;
    logic             uflow;
    logic             first_val;
    logic [CHW-1:0]   first_ch;
    logic [CW-1:0]    first_idx;
    logic [PW-1:0]    first_exp;
    logic [PW-1:0]    first_obs;

    int total = 0;
    int bad   = 0;

    pec_psum_checker dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .REF_Val_i      (ref_val),
        .REF_Rdy_o      (ref_rdy),
        .REF_Ch_i       (ref_ch),
        .REF_Dat_i      (ref_dat),
        .MON_EnWr_i     (mon_en),
        .MON_DatWr_i    (mon_dat),
        .CHK_Start_i    (chk_start),
        .CHK_Len_i      (chk_len),
        .CHK_Tol_i      (chk_tol),
        .CHK_Busy_o     (busy),
        .CHK_Done_o     (done),
        .CHK_Cnt_o      (chk_cnt),
        .ERR_Cnt_o      (err_cnt),
        .ERR_Uflow_o    (uflow),
        .ERR_FirstVal_o (first_val),
        .ERR_FirstCh_o  (first_ch),
        .ERR_FirstIdx_o (first_idx),
        .ERR_FirstExp_o (first_exp),
        .ERR_FirstObs_o (first_obs)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [PW-1:0] v);
        ref_val = 1'b1;
        ref_ch  = CHW'(ch);
        ref_dat = v;
        tick();
        ref_val = 1'b0;
    endtask

    task automatic start(input int len);
        chk_start = 1'b1;
        chk_len   = CW'(len);
        tick();
        chk_start = 1'b0;
    endtask

    task automatic strobe(input int ch, input logic [PW-1:0] v);
        mon_en[ch]            = 1'b1;
        mon_dat[ch*PW +: PW] = v;
    endtask

    task automatic fire();
        tick();
        mon_en = '0;
    endtask

    initial begin
        rst = 1'b1; ref_val = 1'b0; ref_ch = '0; ref_dat = '0;
        mon_en = '0; mon_dat = '0; chk_start = 1'b0; chk_len = '0; chk_tol = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdy",   64'(ref_rdy),   64'd1);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_cnt",   64'(chk_cnt),   64'd0);
        chk("rst_err",   64'(err_cnt),   64'd0);
        chk("rst_uflow", 64'(uflow),     64'd0);
        chk("rst_fval",  64'(first_val), 64'd0);

        // exact stream on ch0..2, 4 entries each
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 3; c++)
                push(c, PW'(c*16 + k + 1));
        start(12);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cnt0", 64'(chk_cnt), 64'd0);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++)
                strobe(c, PW'(c*16 + k + 1));
            fire();
            chk("t1_cnt", 64'(chk_cnt), 64'(3*(k+1)));
        end
        chk("t1_busy_at_len", 64'(busy), 64'd1);
        tick();
        chk("t1_done",  64'(done),      64'd1);
        chk("t1_busy2", 64'(busy),      64'd0);
        chk("t1_err",   64'(err_cnt),   64'd0);
        chk("t1_fval",  64'(first_val), 64'd0);

        // simultaneous errors on ch3 and ch5, ch4 matching
        push(1, 22'h44);
        push(3, 22'h111);
        push(4, 22'h333);
        push(5, 22'h222);
        push(6, 22'h55);
        start(10);
        chk("t2_clr_cnt", 64'(chk_cnt), 64'd0);
        strobe(1, 22'h44);
        fire();
        chk("t2_cnt1", 64'(chk_cnt), 64'd1);
        strobe(5, 22'h2FF);
        strobe(4, 22'h333);
        strobe(3, 22'h110);
        fire();
        chk("t2_cnt",  64'(chk_cnt),   64'd4);
        chk("t2_err",  64'(err_cnt),   64'd2);
        chk("t2_fval", 64'(first_val), 64'd1);
        chk("t2_fch",  64'(first_ch),  64'd3);
        chk("t2_fexp", 64'(first_exp), 64'h111);
        chk("t2_fobs", 64'(first_obs), 64'h110);
        chk("t2_fidx", 64'(first_idx), 64'd1);
        strobe(6, 22'h56);
        fire();
        chk("t2_err3",  64'(err_cnt),  64'd3);
        chk("t2_fch_kept", 64'(first_ch), 64'd3);

        // full FIFO on ch0 with push and pop in the same cycle
        for (int k = 0; k < 8; k++)
            push(0, PW'(32'hA0 + k));
        ref_ch = '0;
        #1;
        chk("t3_full_rdy", 64'(ref_rdy), 64'd0);
        ref_val = 1'b1; ref_dat = 22'hEE;
        strobe(0, 22'hA0);
        #1;
        chk("t3_rdy_prepop", 64'(ref_rdy), 64'd0);
        fire();
        ref_val = 1'b0;
        chk("t3_cnt", 64'(chk_cnt), 64'd6);
        chk("t3_err", 64'(err_cnt), 64'd3);
        chk("t3_rdy_occ7", 64'(ref_rdy), 64'd1);
        push(0, 22'hA8);
        chk("t3_rdy_occ8", 64'(ref_rdy), 64'd0);
        strobe(0, 22'hA1);
        fire();
        chk("t3_err_after_pop", 64'(err_cnt), 64'd3);

        // underflow on ch7, then a clean push/strobe
        start(4);
        strobe(7, 22'h77);
        fire();
        chk("t4_uflow", 64'(uflow),    64'd1);
        chk("t4_err",   64'(err_cnt),  64'd1);
        chk("t4_cnt",   64'(chk_cnt),  64'd1);
        chk("t4_fch",   64'(first_ch), 64'd7);
        push(7, 22'h78);
        strobe(7, 22'h78);
        fire();
        chk("t4_err_clean", 64'(err_cnt), 64'd1);
        chk("t4_cnt2",      64'(chk_cnt), 64'd2);

        // final-cycle truncation: 3 strobes with 2 checks left, ch9 left unpopped
        push(8, 22'h80);
        push(9, 22'h90);
        strobe(0, 22'hA2);
        strobe(8, 22'h80);
        strobe(9, 22'h90);
        fire();
        chk("t5_clamp", 64'(chk_cnt), 64'd4);
        chk("t5_err",   64'(err_cnt), 64'd1);
        tick();
        chk("t5_done", 64'(done), 64'd1);
        strobe(9, 22'h12345);
        fire();
        chk("t5_ignored_cnt", 64'(chk_cnt), 64'd4);
        chk("t5_ignored_err", 64'(err_cnt), 64'd1);
        start(1);
        strobe(9, 22'h90);
        fire();
        chk("t5_ch9_kept_err", 64'(err_cnt), 64'd0);
        chk("t5_ch9_kept_cnt", 64'(chk_cnt), 64'd1);

        // zero length
        start(0);
        chk("t6_busy", 64'(busy), 64'd1);
        tick();
        chk("t6_done", 64'(done), 64'd1);

        // reset mid-run with ERR_Cnt=3
        start(20);
        strobe(10, 22'h1);
        strobe(11, 22'h2);
        strobe(12, 22'h3);
        fire();
        chk("t7_err3", 64'(err_cnt),  64'd3);
        chk("t7_fch",  64'(first_ch), 64'd10);
        ref_ch = '0;
        rst = 1'b1;
        strobe(0, 22'hA3);
        fire();
        rst = 1'b0;
        chk("t7_rdy",   64'(ref_rdy),   64'd1);
        chk("t7_busy",  64'(busy),      64'd0);
        chk("t7_done",  64'(done),      64'd0);
        chk("t7_cnt",   64'(chk_cnt),   64'd0);
        chk("t7_err",   64'(err_cnt),   64'd0);
        chk("t7_uflow", 64'(uflow),     64'd0);
        chk("t7_fval",  64'(first_val), 64'd0);
        chk("t7_fch0",  64'(first_ch),  64'd0);
        chk("t7_fidx",  64'(first_idx), 64'd0);
        chk("t7_fexp",  64'(first_exp), 64'd0);
        chk("t7_fobs",  64'(first_obs), 64'd0);
        start(1);
        strobe(0, 22'hA3);
        fire();
        chk("t7_fifo_empty_uflow", 64'(uflow),   64'd1);
        chk("t7_fifo_empty_err",   64'(err_cnt), 64'd1);

`ifdef CHK_TOLERANCE_EN
        start(4);
        push(0, PW'(100));
        chk_tol = PW'(2);
        strobe(0, PW'(102));
        fire();
        chk("tol_pos_pass", 64'(err_cnt), 64'd0);
        push(0, PW'(100));
        chk_tol = PW'(1);
        strobe(0, PW'(102));
        fire();
        chk("tol_pos_fail", 64'(err_cnt), 64'd1);
        push(0, PW'(-5));
        chk_tol = PW'(3);
        strobe(0, PW'(-8));
        fire();
        chk("tol_neg_pass", 64'(err_cnt), 64'd1);
        push(0, PW'(-5));
        chk_tol = PW'(2);
        strobe(0, PW'(-8));
        fire();
        chk("tol_neg_fail", 64'(err_cnt), 64'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
